// File: rtl/kanagawa_fifo_read_width_downsizer.sv
// Purpose: split each IN_WIDTH show-ahead FIFO word into RATIO narrower show-ahead beats.
// Latency: one cycle from upstream word visible to beat 0 presented (stage empty).
// Backpressure: downstream stall holds word/beat index; upstream popped only on reload.
module kanagawa_fifo_read_width_downsizer #(
    parameter int IN_WIDTH  = 64,
    parameter int RATIO     = 4,
    parameter int LSB_FIRST = 1,
    localparam int OUT_WIDTH = IN_WIDTH / RATIO,
    localparam int CNT_W     = (RATIO > 1) ? $clog2(RATIO) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 rdreq_out,
    input  logic                 rdempty_in,
    input  logic [IN_WIDTH-1:0]  rddata_in,
    input  logic                 rdreq_in,
    output logic                 rdempty_out,
    output logic [OUT_WIDTH-1:0] rddata_out,
    output logic                 rdlast_out
);

    // IN_WIDTH must be an exact multiple of RATIO; any remainder bits are never presented.
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(RATIO - 1);

    logic [IN_WIDTH-1:0] word_q, word_d;
    logic                valid_q, valid_d;
    logic [CNT_W-1:0]    idx_q, idx_d;

    logic pop;
    logic last_beat;
    logic load;

    // Beat bookkeeping: reload as soon as the held word is gone or its last beat leaves.
    always_comb begin
        pop       = rdreq_in & valid_q;
        last_beat = valid_q & (idx_q == LAST_IDX);
        load      = ~rdempty_in & (~valid_q | (pop & last_beat));

        word_d  = word_q;
        valid_d = valid_q;
        idx_d   = idx_q;

        if (load) begin
            word_d  = rddata_in;
            valid_d = 1'b1;
            idx_d   = '0;
        end else if (pop) begin
            if (last_beat) begin
                valid_d = 1'b0;
                idx_d   = '0;
            end else begin
                idx_d = idx_q + CNT_W'(1);
            end
        end
    end

    // Holding register; reset discards any partially consumed word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q  <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            word_q  <= word_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
        end
    end

    // Beat select: compare against each legal index so a non-power-of-2 RATIO never
    // addresses past the word.
    always_comb begin
        rddata_out = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (idx_q == CNT_W'(i)) begin
                rddata_out = word_q[((LSB_FIRST != 0) ? i : (RATIO - 1 - i)) * OUT_WIDTH +: OUT_WIDTH];
            end
        end
    end

    // rst_n gating keeps the upstream pop quiet while reset is held.
    assign rdreq_out   = load & rst_n;
    assign rdempty_out = ~valid_q;
    assign rdlast_out  = last_beat;

endmodule

// File: tb/tb_kanagawa_fifo_read_width_downsizer.sv
module tb_kanagawa_fifo_read_width_downsizer;

    logic       clk;
    logic       rst_n;
    logic [3:0] rdreq_out;
    logic [3:0] rdempty_in;
    logic [3:0] rdreq_in;
    logic [3:0] rdempty_out;
    logic [3:0] rdlast_out;
    logic [3:0] gate;

    logic [15:0] dat0, dat1, dat2;
    logic [63:0] dat3;
    logic [63:0] din0, din1, din3;
    logic [47:0] din2;

    // Upstream show-ahead FIFO models, one per instance:
    // 0: 64/4 LSB first, 1: 64/4 MSB first, 2: 48/3 LSB first, 3: 64/1
    logic [63:0] mem [4][2048];
    int head [4] = '{default: 0};
    int tail [4] = '{default: 0};

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    assign din0 = mem[0][head[0]];
    assign din1 = mem[1][head[1]];
    assign din2 = mem[2][head[2]][47:0];
    assign din3 = mem[3][head[3]];

    assign rdempty_in[0] = (head[0] == tail[0]) | gate[0];
    assign rdempty_in[1] = (head[1] == tail[1]) | gate[1];
    assign rdempty_in[2] = (head[2] == tail[2]) | gate[2];
    assign rdempty_in[3] = (head[3] == tail[3]) | gate[3];

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rdreq_out[k]) head[k] <= head[k] + 1;
        end
    end

    kanagawa_fifo_read_width_downsizer #(.IN_WIDTH(64), .RATIO(4), .LSB_FIRST(1)) u_r4 (
        .clk(clk), .rst_n(rst_n), .rdreq_out(rdreq_out[0]), .rdempty_in(rdempty_in[0]),
        .rddata_in(din0), .rdreq_in(rdreq_in[0]), .rdempty_out(rdempty_out[0]),
        .rddata_out(dat0), .rdlast_out(rdlast_out[0]));

    kanagawa_fifo_read_width_downsizer #(.IN_WIDTH(64), .RATIO(4), .LSB_FIRST(0)) u_r4m (
        .clk(clk), .rst_n(rst_n), .rdreq_out(rdreq_out[1]), .rdempty_in(rdempty_in[1]),
        .rddata_in(din1), .rdreq_in(rdreq_in[1]), .rdempty_out(rdempty_out[1]),
        .rddata_out(dat1), .rdlast_out(rdlast_out[1]));

    kanagawa_fifo_read_width_downsizer #(.IN_WIDTH(48), .RATIO(3), .LSB_FIRST(1)) u_r3 (
        .clk(clk), .rst_n(rst_n), .rdreq_out(rdreq_out[2]), .rdempty_in(rdempty_in[2]),
        .rddata_in(din2), .rdreq_in(rdreq_in[2]), .rdempty_out(rdempty_out[2]),
        .rddata_out(dat2), .rdlast_out(rdlast_out[2]));

    kanagawa_fifo_read_width_downsizer #(.IN_WIDTH(64), .RATIO(1), .LSB_FIRST(1)) u_r1 (
        .clk(clk), .rst_n(rst_n), .rdreq_out(rdreq_out[3]), .rdempty_in(rdempty_in[3]),
        .rddata_in(din3), .rdreq_in(rdreq_in[3]), .rdempty_out(rdempty_out[3]),
        .rddata_out(dat3), .rdlast_out(rdlast_out[3]));

    task automatic push(input int k, input logic [63:0] w);
        mem[k][tail[k]] = w;
        tail[k] = tail[k] + 1;
    endtask

    task automatic test_reset();
        logic [63:0] w;
        w = 64'h0123_4567_89AB_CDEF;
        push(3, w);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({rdempty_out[k], rdlast_out[k], rdreq_out[k]} !== 3'b100)
                $display("FAIL reset_flags[%0d]: got empty/last/req %b required 100", k,
                         {rdempty_out[k], rdlast_out[k], rdreq_out[k]});
            else passed++;
        end
        checks++;
        if (dat0 !== 16'h0 || dat3 !== 64'h0)
            $display("FAIL reset_data: got %h/%h required 0/0", dat0, dat3);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (rdreq_out[3] !== 1'b1) $display("FAIL release_rdreq: got %b required 1", rdreq_out[3]);
        else passed++;
        rdreq_in[3] = 1'b1;
        @(negedge clk);
        checks++;
        if (dat3 !== w || rdlast_out[3] !== 1'b1 || rdempty_out[3] !== 1'b0)
            $display("FAIL release_first_word: got %h last %b empty %b required %h 1 0",
                     dat3, rdlast_out[3], rdempty_out[3], w);
        else passed++;
        @(negedge clk);
        checks++;
        if (rdempty_out[3] !== 1'b1) $display("FAIL release_drain: got empty %b required 1", rdempty_out[3]);
        else passed++;
    endtask

    task automatic test_lsb_first();
        logic [15:0] e [4];
        e = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        rdreq_in[0] = 1'b1;
        push(0, 64'h4444_3333_2222_1111);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            checks++;
            if (dat0 !== e[b] || rdlast_out[0] !== (b == 3) || rdempty_out[0] !== 1'b0)
                $display("FAIL lsb_beat%0d: got %h last %b empty %b required %h last %b empty 0",
                         b, dat0, rdlast_out[0], rdempty_out[0], e[b], (b == 3));
            else passed++;
        end
        @(negedge clk);
        checks++;
        if (rdempty_out[0] !== 1'b1) $display("FAIL lsb_drain: got empty %b required 1", rdempty_out[0]);
        else passed++;
        rdreq_in[0] = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [15:0] e [8];
        e = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777, 16'h8888};
        rdreq_in[0] = 1'b1;
        push(0, 64'h4444_3333_2222_1111);
        push(0, 64'h8888_7777_6666_5555);
        #1;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            checks++;
            if (rdreq_out[0] !== (c == 0 || c == 4))
                $display("FAIL b2b_rdreq_c%0d: got %b required %b", c, rdreq_out[0], (c == 0 || c == 4));
            else passed++;
            if (c >= 1 && c <= 8) begin
                checks++;
                if (dat0 !== e[c-1] || rdempty_out[0] !== 1'b0 || rdlast_out[0] !== (c == 4 || c == 8))
                    $display("FAIL b2b_beat_c%0d: got %h empty %b last %b required %h empty 0 last %b",
                             c, dat0, rdempty_out[0], rdlast_out[0], e[c-1], (c == 4 || c == 8));
                else passed++;
            end
        end
        checks++;
        if (rdempty_out[0] !== 1'b1) $display("FAIL b2b_drain: got empty %b required 1", rdempty_out[0]);
        else passed++;
        rdreq_in[0] = 1'b0;
    endtask

    task automatic test_msb_first();
        logic [15:0] e [4];
        e = '{16'h4444, 16'h3333, 16'h2222, 16'h1111};
        rdreq_in[1] = 1'b1;
        push(1, 64'h4444_3333_2222_1111);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            checks++;
            if (dat1 !== e[b] || rdlast_out[1] !== (b == 3) || rdempty_out[1] !== 1'b0)
                $display("FAIL msb_beat%0d: got %h last %b empty %b required %h last %b empty 0",
                         b, dat1, rdlast_out[1], rdempty_out[1], e[b], (b == 3));
            else passed++;
        end
        rdreq_in[1] = 1'b0;
    endtask

    task automatic test_random_stalls();
        logic [16:0] sb [$];
        logic [63:0] w;
        logic        prev_vld, prev_req;
        logic [15:0] prev_dat;
        int          cyc;
        for (int i = 0; i < 1000; i++) begin
            w = {$urandom, $urandom};
            push(0, w);
            for (int b = 0; b < 4; b++) sb.push_back({(b == 3), w[16*b +: 16]});
        end
        prev_vld = 1'b0;
        prev_req = 1'b0;
        prev_dat = '0;
        cyc = 0;
        while (sb.size() > 0 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (prev_vld && !prev_req) begin
                checks++;
                if (rdempty_out[0] !== 1'b0 || dat0 !== prev_dat)
                    $display("FAIL stall_hold: got %h empty %b required %h empty 0", dat0, rdempty_out[0], prev_dat);
                else passed++;
            end
            if (!rdempty_out[0]) begin
                checks++;
                if ({rdlast_out[0], dat0} !== sb[0])
                    $display("FAIL rand_beat: got last %b data %h required last %b data %h",
                             rdlast_out[0], dat0, sb[0][16], sb[0][15:0]);
                else passed++;
            end
            gate[0]     = ($urandom_range(0, 3) == 0);
            rdreq_in[0] = 1'($urandom_range(0, 1));
            if (rdreq_in[0] && !rdempty_out[0]) void'(sb.pop_front());
            prev_vld = !rdempty_out[0];
            prev_req = rdreq_in[0];
            prev_dat = dat0;
        end
        checks++;
        if (sb.size() != 0) $display("FAIL rand_timeout: got %0d beats left required 0", sb.size());
        else passed++;
        @(negedge clk);
        gate[0]     = 1'b0;
        rdreq_in[0] = 1'b0;
    endtask

    task automatic test_reset_mid_word();
        int h_before;
        @(negedge clk);
        rdreq_in[0] = 1'b1;
        push(0, 64'hDDDD_CCCC_BBBB_AAAA);
        push(0, 64'h5678_1234_9ABC_DEF0);
        repeat (3) @(negedge clk);
        checks++;
        if (dat0 !== 16'hCCCC) $display("FAIL midrst_pre: got %h required cccc", dat0);
        else passed++;
        rdreq_in[0] = 1'b0;
        rst_n = 1'b0;
        h_before = head[0];
        #1;
        checks++;
        if (rdempty_out[0] !== 1'b1 || rdreq_out[0] !== 1'b0 || dat0 !== 16'h0)
            $display("FAIL midrst_async: got empty %b req %b data %h required 1 0 0000",
                     rdempty_out[0], rdreq_out[0], dat0);
        else passed++;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (rdreq_out[0] !== 1'b0 || head[0] != h_before)
                $display("FAIL midrst_nopop: got req %b pops %0d required 0 0", rdreq_out[0], head[0] - h_before);
            else passed++;
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (rdreq_out[0] !== 1'b1) $display("FAIL midrst_release_req: got %b required 1", rdreq_out[0]);
        else passed++;
        rdreq_in[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (dat0 !== 16'hDEF0 || rdempty_out[0] !== 1'b0)
            $display("FAIL midrst_next_word: got %h empty %b required def0 empty 0", dat0, rdempty_out[0]);
        else passed++;
        repeat (4) @(negedge clk);
        rdreq_in[0] = 1'b0;
        checks++;
        if (rdempty_out[0] !== 1'b1) $display("FAIL midrst_drain: got empty %b required 1", rdempty_out[0]);
        else passed++;
    endtask

    task automatic test_ratio3();
        logic [15:0] e [6];
        e = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'h1111, 16'h2222, 16'h3333};
        rdreq_in[2] = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (rdempty_out[2] !== 1'b1 || rdlast_out[2] !== 1'b0 || rdreq_out[2] !== 1'b0)
                $display("FAIL r3_idle_req: got empty %b last %b req %b required 1 0 0",
                         rdempty_out[2], rdlast_out[2], rdreq_out[2]);
            else passed++;
        end
        push(2, 64'h0000_CCCC_BBBB_AAAA);
        push(2, 64'h0000_3333_2222_1111);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (dat2 !== e[c] || rdempty_out[2] !== 1'b0 || rdlast_out[2] !== (c == 2 || c == 5))
                $display("FAIL r3_beat%0d: got %h empty %b last %b required %h empty 0 last %b",
                         c, dat2, rdempty_out[2], rdlast_out[2], e[c], (c == 2 || c == 5));
            else passed++;
        end
        @(negedge clk);
        checks++;
        if (rdempty_out[2] !== 1'b1) $display("FAIL r3_drain: got empty %b required 1", rdempty_out[2]);
        else passed++;
        rdreq_in[2] = 1'b0;
    endtask

    task automatic test_ratio1();
        logic [63:0] e [3];
        e = '{64'h1111_0000_AAAA_5555, 64'h2222_0000_BBBB_6666, 64'h3333_0000_CCCC_7777};
        rdreq_in[3] = 1'b1;
        for (int i = 0; i < 3; i++) push(3, e[i]);
        #1;
        checks++;
        if (rdreq_out[3] !== 1'b1) $display("FAIL r1_rdreq_c0: got %b required 1", rdreq_out[3]);
        else passed++;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            checks++;
            if (dat3 !== e[c-1] || rdlast_out[3] !== 1'b1 || rdempty_out[3] !== 1'b0 || rdreq_out[3] !== (c < 3))
                $display("FAIL r1_beat%0d: got %h last %b empty %b req %b required %h 1 0 %b",
                         c, dat3, rdlast_out[3], rdempty_out[3], rdreq_out[3], e[c-1], (c < 3));
            else passed++;
        end
        @(negedge clk);
        checks++;
        if (rdempty_out[3] !== 1'b1) $display("FAIL r1_drain: got empty %b required 1", rdempty_out[3]);
        else passed++;
        rdreq_in[3] = 1'b0;
    endtask

    initial begin
        clk      = 1'b0;
        rst_n    = 1'b0;
        rdreq_in = '0;
        gate     = '0;
        test_reset();
        test_lsb_first();
        test_back_to_back();
        test_msb_first();
        test_random_stalls();
        test_reset_mid_word();
        test_ratio3();
        test_ratio1();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
